// File: rtl/netbus_pkg.sv
// netbus_pkg: shared constants and types for the NetBus 6-port receive arbiter.
//   NPORT      - number of receive ports sharing the upstream read channel
//   PORT_ID_W  - width of a binary port index
//   BEAT_CNT_W - width of the per-packet beat counter
//   arb_state_t - arbiter FSM state (IDLE / BUSY)
package netbus_pkg;

  localparam int NPORT      = 6;
  localparam int PORT_ID_W  = 3;
  localparam int BEAT_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/net_bus_rr_pick6.sv
// net_bus_rr_pick6: combinational winner selection for the 6-port arbiter.
// Ports:
//   req     in  6  pending requests
//   rt_mask in  6  real-time port mask (strict priority, lowest index first)
//   rr_ptr  in  3  round-robin base; search starts at rr_ptr+1 (mod 6)
//   win_oh  out 6  one-hot winner (zero when no request)
//   win_id  out 3  binary winner index (zero when no request)
//   any_req out 1  at least one request pending
module net_bus_rr_pick6
  import netbus_pkg::*;
(
  input  logic [NPORT-1:0]     req,
  input  logic [NPORT-1:0]     rt_mask,
  input  logic [PORT_ID_W-1:0] rr_ptr,
  output logic [NPORT-1:0]     win_oh,
  output logic [PORT_ID_W-1:0] win_id,
  output logic                 any_req
);

  logic [NPORT-1:0]     rt_req;
  logic                 found;
  int                   idx;
  logic [PORT_ID_W-1:0] idx_w;

  always_comb begin
    rt_req = req & rt_mask;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    idx_w  = '0;
    if (rt_req != '0) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!found && rt_req[i]) begin
          found  = 1'b1;
          win_id = PORT_ID_W'(i);
        end
      end
    end else begin
      // rr_ptr never exceeds 5, so one conditional subtract is a full mod-6.
      for (int k = 1; k <= NPORT; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NPORT) idx = idx - NPORT;
        idx_w = PORT_ID_W'(idx);
        if (!found && req[idx_w]) begin
          found  = 1'b1;
          win_id = idx_w;
        end
      end
    end
    win_oh         = '0;
    win_oh[win_id] = found;
    any_req        = |req;
  end

endmodule

// File: rtl/net_bus_arb6.sv
// net_bus_arb6: packet-level arbiter sharing the upstream read channel of the
// 6-port NetBus mux. Real-time ports have strict priority, the rest are served
// round-robin; a grant is held until the granted port's LAST beat is accepted.
//
// Handshake: a beat transfers on a cycle where gnt_valid=1, accept=1 and
// req[gnt_id]=1. accept without a granted, requesting port is ignored.
//
// Ports:
//   clk       in  1   arbitration clock (receive-side read clock)
//   reset     in  1   synchronous active-high reset
//   req       in  6   per-port beat pending (RVALID)
//   last      in  6   per-port pending beat is end of packet
//   accept    in  1   upstream consumed the granted beat
//   gnt       out 6   one-hot grant, zero when idle
//   gnt_id    out 3   granted port index, zero when idle
//   gnt_valid out 1   grant active
//   beat_cnt  out 16  beats accepted in current packet (saturating)
//   timeout   out 1   one-cycle pulse on forced release
//   dbg_state out     current FSM state
//
// Optional feature macro: NETBUS_ARB_TIMEOUT_EN -- when defined, a grant that
// sees no beat for TIMEOUT_CYCLES cycles is force-released; otherwise timeout=0.
module net_bus_arb6
  import netbus_pkg::*;
#(
  parameter int                        NPORT          = netbus_pkg::NPORT,
  parameter logic [netbus_pkg::NPORT-1:0] REAL_TIME_MASK = '0,
  parameter int                        TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      last,
  input  logic                  accept,
  output logic [NPORT-1:0]      gnt,
  output logic [PORT_ID_W-1:0]  gnt_id,
  output logic                  gnt_valid,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output logic                  timeout,
  output arb_state_t            dbg_state
);

  if (NPORT != 6) begin : g_bad_nport
    $error("net_bus_arb6 supports exactly 6 ports");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("net_bus_arb6 TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t           state;
  logic [PORT_ID_W-1:0] rr_ptr;
  logic [PORT_ID_W-1:0] pick_ptr;
  logic [NPORT-1:0]     win_oh;
  logic [PORT_ID_W-1:0] win_id;
  logic                 any_req;
  logic                 beat;
  logic                 eop;
  logic                 stall_fire;
  logic                 release_gnt;

  // While busy the picker only matters on the release edge, where the new
  // round-robin base is the port being released; using it throughout lets the
  // next packet be granted on the same edge with no idle bubble.
  assign pick_ptr    = (state == BUSY) ? gnt_id : rr_ptr;
  assign beat        = gnt_valid & accept & req[gnt_id];
  assign eop         = beat & last[gnt_id];
  assign release_gnt = eop | stall_fire;
  assign dbg_state   = state;

  net_bus_rr_pick6 u_pick (
    .req     (req),
    .rt_mask (REAL_TIME_MASK),
    .rr_ptr  (pick_ptr),
    .win_oh  (win_oh),
    .win_id  (win_id),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      beat_cnt  <= '0;
      rr_ptr    <= PORT_ID_W'(5);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= win_oh;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_gnt) begin
            rr_ptr   <= gnt_id;
            beat_cnt <= '0;
            if (any_req) begin
              gnt    <= win_oh;
              gnt_id <= win_id;
            end else begin
              gnt       <= '0;
              gnt_id    <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end else if (beat && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NETBUS_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;

  assign stall_fire = (state == BUSY) && !beat &&
                      (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  // Restart on every beat and on every new grant (release always regrants or
  // goes idle, and the counter is held at zero while idle).
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= stall_fire;
      if ((state != BUSY) || beat || release_gnt) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end
`else
  assign stall_fire = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_net_bus_arb6.sv
module tb_net_bus_arb6;
  import netbus_pkg::*;

  localparam int         TC      = 8;
  localparam logic [5:0] RT_MASK = 6'b100000;
`ifdef NETBUS_ARB_TIMEOUT_EN
  localparam int STALL_N = 6;
`else
  localparam int STALL_N = 10;
`endif

  logic        clk;
  logic        reset;
  logic [5:0]  req;
  logic [5:0]  last;
  logic        accept;

  logic [5:0]  gnt;
  logic [2:0]  gnt_id;
  logic        gnt_valid;
  logic [15:0] beat_cnt;
  logic        timeout;
  arb_state_t  dbg_state;

  logic [5:0]  gnt_rt;
  logic [2:0]  gnt_id_rt;
  logic        gnt_valid_rt;
  logic [15:0] beat_cnt_rt;
  logic        timeout_rt;
  arb_state_t  dbg_state_rt;

  int checks;
  int failures;
  logic [21:0] exp_q[$];

  // reference model state (main instance, no real-time ports)
  bit   m_valid;
  int   m_id;
  int   m_ptr;
  int   m_cnt;
  int   m_stall;
  bit   m_to;
  bit   m_rel;
  int   wait_pk[6];

  net_bus_arb6 #(.REAL_TIME_MASK(6'b000000), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .accept(accept),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .beat_cnt(beat_cnt),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  net_bus_arb6 #(.REAL_TIME_MASK(RT_MASK), .TIMEOUT_CYCLES(TC)) dut_rt (
    .clk(clk), .reset(reset), .req(req), .last(last), .accept(accept),
    .gnt(gnt_rt), .gnt_id(gnt_id_rt), .gnt_valid(gnt_valid_rt), .beat_cnt(beat_cnt_rt),
    .timeout(timeout_rt), .dbg_state(dbg_state_rt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; last = '0; accept = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(logic [5:0] r, int ptr, logic [5:0] mask);
    int w = -1;
    for (int i = 0; i < 6; i++) if (w < 0 && r[i] && mask[i]) w = i;
    if (w < 0) begin
      for (int k = 1; k <= 6; k++) begin
        int p = (ptr + k) % 6;
        if (w < 0 && r[p]) w = p;
      end
    end
    return w;
  endfunction

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (gnt !== 6'd0)        begin failures++; $display("FAIL reset_gnt got %h want 00", gnt); end
    if (gnt_id !== 3'd0)     begin failures++; $display("FAIL reset_gnt_id got %0d want 0", gnt_id); end
    if (gnt_valid !== 1'b0)  begin failures++; $display("FAIL reset_gnt_valid got %b want 0", gnt_valid); end
    if (beat_cnt !== 16'd0)  begin failures++; $display("FAIL reset_beat_cnt got %h want 0", beat_cnt); end
    if (timeout !== 1'b0)    begin failures++; $display("FAIL reset_timeout got %b want 0", timeout); end
    if (gnt_rt !== 6'd0)     begin failures++; $display("FAIL reset_gnt_rt got %h want 00", gnt_rt); end
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (gnt_valid !== 1'b0)  begin failures++; $display("FAIL idle_no_req_valid got %b want 0", gnt_valid); end
    if (dbg_state !== IDLE)  begin failures++; $display("FAIL idle_no_req_state got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_round_robin();
    logic [21:0] e;
    do_reset();
    reset = 1'b0; req = 6'b000111; last = 6'b000111; accept = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back({6'(1 << (i % 3)), 16'd0});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 3;
      if ({gnt, beat_cnt} !== e) begin failures++; $display("FAIL rr_gnt step %0d got %h/%h want %h/%h", i, gnt, beat_cnt, e[21:16], e[15:0]); end
      if (gnt_valid !== 1'b1) begin failures++; $display("FAIL rr_valid step %0d got %b want 1", i, gnt_valid); end
      if (gnt_id !== 3'(i % 3)) begin failures++; $display("FAIL rr_gnt_id step %0d got %0d want %0d", i, gnt_id, i % 3); end
    end
  endtask

  task automatic test_rt_preempt();
    logic [21:0] e;
    do_reset();
    reset = 1'b0; req = 6'b000010; last = 6'b000000; accept = 1'b1;
    exp_q.push_back({6'b000010, 16'd0});
    exp_q.push_back({6'b000010, 16'd1});
    exp_q.push_back({6'b000010, 16'd2});
    exp_q.push_back({6'b000010, 16'd3});
    exp_q.push_back({6'b100000, 16'd0});
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({gnt_rt, beat_cnt_rt} !== e) begin failures++; $display("FAIL rt_gnt step %0d got %h/%h want %h/%h", s, gnt_rt, beat_cnt_rt, e[21:16], e[15:0]); end
      if (s == 1) req = 6'b100010;
      if (s == 3) last = 6'b000010;
    end
    checks++;
    if (gnt_id_rt !== 3'd5) begin failures++; $display("FAIL rt_gnt_id got %0d want 5", gnt_id_rt); end
  endtask

  task automatic test_stall();
    logic [21:0] e;
    do_reset();
    reset = 1'b0; req = 6'b001000; last = 6'b001000; accept = 1'b0;
    for (int s = 0; s < STALL_N; s++) exp_q.push_back({6'b001000, 16'd0});
    exp_q.push_back({6'b000001, 16'd0});
    for (int s = 0; s <= STALL_N; s++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 2;
      if ({gnt, beat_cnt} !== e) begin failures++; $display("FAIL stall_gnt step %0d got %h/%h want %h/%h", s, gnt, beat_cnt, e[21:16], e[15:0]); end
      if (timeout !== 1'b0) begin failures++; $display("FAIL stall_timeout step %0d got %b want 0", s, timeout); end
      if (s == STALL_N - 1) begin accept = 1'b1; req = 6'b001001; end
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] e;
    do_reset();
    reset = 1'b0; req = 6'b010000; last = 6'b000000; accept = 1'b1;
    for (int s = 0; s < 3; s++) exp_q.push_back({6'b010000, 16'(s)});
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, beat_cnt} !== e) begin failures++; $display("FAIL mid_pkt step %0d got %h/%h want %h/%h", s, gnt, beat_cnt, e[21:16], e[15:0]); end
    end
    reset = 1'b1;
    @(negedge clk);
    checks += 3;
    if (gnt !== 6'd0)       begin failures++; $display("FAIL mid_reset_gnt got %h want 00", gnt); end
    if (gnt_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got %b want 0", gnt_valid); end
    if (beat_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_cnt got %h want 0", beat_cnt); end
    reset = 1'b0; req = 6'b010001;
    @(negedge clk);
    checks += 2;
    if (gnt !== 6'b000001) begin failures++; $display("FAIL post_reset_gnt got %h want 01", gnt); end
    if (gnt_id !== 3'd0)   begin failures++; $display("FAIL post_reset_gnt_id got %0d want 0", gnt_id); end
  endtask

`ifdef NETBUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [21:0] e;
    logic        exp_to;
    do_reset();
    reset = 1'b0; req = 6'b001100; last = 6'b000000; accept = 1'b0;
    for (int s = 0; s < 8; s++) exp_q.push_back({6'b000100, 16'd0});
    exp_q.push_back({6'b001000, 16'd0});
    exp_q.push_back({6'b001000, 16'd0});
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      exp_to = (s == 8);
      checks += 2;
      if ({gnt, beat_cnt} !== e) begin failures++; $display("FAIL to_gnt step %0d got %h/%h want %h/%h", s, gnt, beat_cnt, e[21:16], e[15:0]); end
      if (timeout !== exp_to) begin failures++; $display("FAIL to_pulse step %0d got %b want %b", s, timeout, exp_to); end
    end
  endtask
`endif

  task automatic model_step();
    bit beat, fire, rel;
    int w;
    int old_id;
    beat   = m_valid && accept && req[m_id];
    fire   = 1'b0;
`ifdef NETBUS_ARB_TIMEOUT_EN
    fire   = m_valid && !beat && (m_stall == TC - 1);
    if (!m_valid || beat || fire || (beat && last[m_id])) m_stall = 0;
    else m_stall++;
    m_to   = fire;
`endif
    rel    = (beat && last[m_id]) || fire;
    old_id = m_id;
    if (!m_valid) begin
      w = pick(req, m_ptr, 6'b000000);
      if (w >= 0) begin m_valid = 1'b1; m_id = w; end
    end else if (rel) begin
      for (int i = 0; i < 6; i++) if (i != old_id && req[i]) wait_pk[i]++;
      m_ptr = m_id;
      m_cnt = 0;
      w = pick(req, m_ptr, 6'b000000);
      if (w >= 0) m_id = w;
      else begin m_valid = 1'b0; m_id = 0; end
    end else if (beat && m_cnt < 65535) begin
      m_cnt++;
    end
    for (int i = 0; i < 6; i++) if (!req[i] || (m_valid && m_id == i)) wait_pk[i] = 0;
    m_rel = rel;
  endtask

  task automatic test_random();
    logic [21:0] e;
    logic [5:0]  m_gnt;
    logic [5:0]  prev_gnt;
    logic        prev_valid;
    int          worst;
    do_reset();
    m_valid = 0; m_id = 0; m_ptr = 5; m_cnt = 0; m_stall = 0; m_to = 0; m_rel = 0;
    for (int i = 0; i < 6; i++) wait_pk[i] = 0;
    reset = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      for (int i = 0; i < 6; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      last   = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
      accept = ($urandom_range(0, 3) != 0);
      prev_gnt   = gnt;
      prev_valid = gnt_valid;
      model_step();
      m_gnt = m_valid ? 6'(1 << m_id) : 6'd0;
      exp_q.push_back({m_gnt, 16'(m_cnt)});
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 5;
      if ({gnt, beat_cnt} !== e) begin failures++; $display("FAIL rand_gnt cycle %0d got %h/%h want %h/%h", n, gnt, beat_cnt, e[21:16], e[15:0]); end
      if (gnt_valid !== m_valid || gnt_id !== 3'(m_id)) begin failures++; $display("FAIL rand_id cycle %0d got %b/%0d want %b/%0d", n, gnt_valid, gnt_id, m_valid, m_id); end
      if (timeout !== m_to) begin failures++; $display("FAIL rand_timeout cycle %0d got %b want %b", n, timeout, m_to); end
      if ((gnt_valid && gnt !== 6'(1 << gnt_id)) || (!gnt_valid && gnt !== 6'd0)) begin
        failures++; $display("FAIL rand_onehot cycle %0d gnt %h id %0d valid %b", n, gnt, gnt_id, gnt_valid);
      end
      if (prev_valid && gnt !== prev_gnt && !m_rel) begin
        failures++; $display("FAIL rand_midpkt cycle %0d got %h was %h", n, gnt, prev_gnt);
      end
      if (m_rel) begin
        worst = 0;
        for (int i = 0; i < 6; i++) if (wait_pk[i] > worst) worst = wait_pk[i];
        checks++;
        if (worst > 5) begin failures++; $display("FAIL rand_fair cycle %0d wait %0d packets, limit 5", n, worst); end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; req = '0; last = '0; accept = 1'b0;
    test_reset();
    test_round_robin();
    test_rt_preempt();
    test_stall();
    test_reset_mid();
`ifdef NETBUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
